// File: rtl/physics_pkg.sv
// Shared definitions for the soft-body point scheduler: default field widths,
// the point record layout, the scheduler state encoding and an address-width helper.
`timescale 1ns/1ps
package physics_pkg;

  localparam int POSITION_SIZE_DEF = 8;
  localparam int VELOCITY_SIZE_DEF = 8;

  typedef struct packed {
    logic [POSITION_SIZE_DEF-1:0] pos_x;
    logic [POSITION_SIZE_DEF-1:0] pos_y;
    logic [VELOCITY_SIZE_DEF-1:0] vel_x;
    logic [VELOCITY_SIZE_DEF-1:0] vel_y;
  } point_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  function automatic int addr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/point_update_scheduler_if.sv
// Handshake between the scheduler (master) and the external update engine (slave):
// one-cycle begin strobe with operands, answered later by a one-cycle result strobe.
`timescale 1ns/1ps
interface point_update_scheduler_if #(
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8
) ();

  logic                     up_begin_out;
  logic [POSITION_SIZE-1:0] up_pos_x_out;
  logic [POSITION_SIZE-1:0] up_pos_y_out;
  logic [VELOCITY_SIZE-1:0] up_vel_x_out;
  logic [VELOCITY_SIZE-1:0] up_vel_y_out;
  logic                     up_result_in;
  logic [POSITION_SIZE-1:0] up_new_pos_x_in;
  logic [POSITION_SIZE-1:0] up_new_pos_y_in;
  logic [VELOCITY_SIZE-1:0] up_new_vel_x_in;
  logic [VELOCITY_SIZE-1:0] up_new_vel_y_in;

  modport master (
    output up_begin_out, up_pos_x_out, up_pos_y_out, up_vel_x_out, up_vel_y_out,
    input  up_result_in, up_new_pos_x_in, up_new_pos_y_in, up_new_vel_x_in, up_new_vel_y_in
  );

  modport slave (
    input  up_begin_out, up_pos_x_out, up_pos_y_out, up_vel_x_out, up_vel_y_out,
    output up_result_in, up_new_pos_x_in, up_new_pos_y_in, up_new_vel_x_in, up_new_vel_y_in
  );

endinterface

// File: rtl/point_store.sv
// Point record storage: one write port, a combinational issue read port for the
// scheduler and a registered renderer read port that returns pre-write data.
`timescale 1ns/1ps
module point_store #(
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int NUM_POINTS    = 8,
  parameter int AW            = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     wr_en_in,
  input  logic [AW-1:0]            wr_addr_in,
  input  logic [POSITION_SIZE-1:0] wr_pos_x_in,
  input  logic [POSITION_SIZE-1:0] wr_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] wr_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] wr_vel_y_in,
  input  logic [AW-1:0]            iss_addr_in,
  output logic [POSITION_SIZE-1:0] iss_pos_x_out,
  output logic [POSITION_SIZE-1:0] iss_pos_y_out,
  output logic [VELOCITY_SIZE-1:0] iss_vel_x_out,
  output logic [VELOCITY_SIZE-1:0] iss_vel_y_out,
  input  logic [AW-1:0]            rd_addr_in,
  output logic [POSITION_SIZE-1:0] rd_pos_x_out,
  output logic [POSITION_SIZE-1:0] rd_pos_y_out
);

  typedef struct packed {
    logic [POSITION_SIZE-1:0] pos_x;
    logic [POSITION_SIZE-1:0] pos_y;
    logic [VELOCITY_SIZE-1:0] vel_x;
    logic [VELOCITY_SIZE-1:0] vel_y;
  } entry_t;

  entry_t                   entries_q [NUM_POINTS];
  entry_t                   entries_d [NUM_POINTS];
  logic [POSITION_SIZE-1:0] rd_pos_x_q, rd_pos_x_d;
  logic [POSITION_SIZE-1:0] rd_pos_y_q, rd_pos_y_d;
  logic                     rd_addr_ok;

  assign rd_addr_ok = (32'(rd_addr_in) < 32'(NUM_POINTS));

  always_comb begin
    entries_d = entries_q;
    if (wr_en_in) begin
      entries_d[wr_addr_in] = '{pos_x: wr_pos_x_in, pos_y: wr_pos_y_in,
                                vel_x: wr_vel_x_in, vel_y: wr_vel_y_in};
    end
  end

  // Reads sample the current contents, so a same-cycle write is not visible yet.
  always_comb begin
    rd_pos_x_d = '0;
    rd_pos_y_d = '0;
    if (rd_addr_ok) begin
      rd_pos_x_d = entries_q[rd_addr_in].pos_x;
      rd_pos_y_d = entries_q[rd_addr_in].pos_y;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_POINTS; i++) begin
        entries_q[i] <= '0;
      end
      rd_pos_x_q <= '0;
      rd_pos_y_q <= '0;
    end else begin
      entries_q  <= entries_d;
      rd_pos_x_q <= rd_pos_x_d;
      rd_pos_y_q <= rd_pos_y_d;
    end
  end

  assign iss_pos_x_out = entries_q[iss_addr_in].pos_x;
  assign iss_pos_y_out = entries_q[iss_addr_in].pos_y;
  assign iss_vel_x_out = entries_q[iss_addr_in].vel_x;
  assign iss_vel_y_out = entries_q[iss_addr_in].vel_y;
  assign rd_pos_x_out  = rd_pos_x_q;
  assign rd_pos_y_out  = rd_pos_y_q;

endmodule

// File: rtl/point_update_scheduler.sv
// Walks every stored point once per frame, handing each to the update engine and
// writing back its answer, or skipping the point and flagging an error on timeout.
`timescale 1ns/1ps
module point_update_scheduler
  import physics_pkg::*;
#(
  parameter int  POSITION_SIZE = POSITION_SIZE_DEF,
  parameter int  VELOCITY_SIZE = VELOCITY_SIZE_DEF,
  parameter int  NUM_POINTS    = 8,
  parameter int  TIMEOUT       = 64,
  localparam int AW            = addr_width(NUM_POINTS)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_start_in,
  output logic                     busy_out,
  output logic                     frame_done_out,
  output logic                     overrun_out,
  output logic                     timeout_err_out,
  input  logic                     cfg_we_in,
  input  logic [AW-1:0]            cfg_addr_in,
  input  logic [POSITION_SIZE-1:0] cfg_pos_x_in,
  input  logic [POSITION_SIZE-1:0] cfg_pos_y_in,
  input  logic [VELOCITY_SIZE-1:0] cfg_vel_x_in,
  input  logic [VELOCITY_SIZE-1:0] cfg_vel_y_in,
  output logic                     cfg_ready_out,
  input  logic [AW-1:0]            rd_addr_in,
  output logic [POSITION_SIZE-1:0] rd_pos_x_out,
  output logic [POSITION_SIZE-1:0] rd_pos_y_out,
  point_update_scheduler_if.master up
);

  localparam int CW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);

  sched_state_e             state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     advance;

  logic                     cfg_addr_ok;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [POSITION_SIZE-1:0] wr_pos_x, wr_pos_y;
  logic [VELOCITY_SIZE-1:0] wr_vel_x, wr_vel_y;
  logic [POSITION_SIZE-1:0] iss_pos_x, iss_pos_y;
  logic [VELOCITY_SIZE-1:0] iss_vel_x, iss_vel_y;
  logic                     operands_live;

  assign cfg_addr_ok = (32'(cfg_addr_in) < 32'(NUM_POINTS));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    advance       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_in) begin
          idx_d         = '0;
          cnt_d         = '0;
          timeout_err_d = 1'b0;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (up.up_result_in) begin
          advance = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          advance       = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A result and a timeout both move on to the next point; only a result writes.
    if (advance) begin
      if (idx_q == AW'(NUM_POINTS - 1)) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = ST_ISSUE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Host writes only land while idle; engine results only land while waiting.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = idx_q;
    wr_pos_x = up.up_new_pos_x_in;
    wr_pos_y = up.up_new_pos_y_in;
    wr_vel_x = up.up_new_vel_x_in;
    wr_vel_y = up.up_new_vel_y_in;
    if (state_q == ST_WAIT && up.up_result_in) begin
      wr_en = 1'b1;
    end else if (state_q == ST_IDLE && cfg_we_in && cfg_addr_ok) begin
      wr_en    = 1'b1;
      wr_addr  = cfg_addr_in;
      wr_pos_x = cfg_pos_x_in;
      wr_pos_y = cfg_pos_y_in;
      wr_vel_x = cfg_vel_x_in;
      wr_vel_y = cfg_vel_y_in;
    end
  end

  point_store #(
    .POSITION_SIZE(POSITION_SIZE),
    .VELOCITY_SIZE(VELOCITY_SIZE),
    .NUM_POINTS   (NUM_POINTS),
    .AW           (AW)
  ) u_store (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_en_in     (wr_en),
    .wr_addr_in   (wr_addr),
    .wr_pos_x_in  (wr_pos_x),
    .wr_pos_y_in  (wr_pos_y),
    .wr_vel_x_in  (wr_vel_x),
    .wr_vel_y_in  (wr_vel_y),
    .iss_addr_in  (idx_q),
    .iss_pos_x_out(iss_pos_x),
    .iss_pos_y_out(iss_pos_y),
    .iss_vel_x_out(iss_vel_x),
    .iss_vel_y_out(iss_vel_y),
    .rd_addr_in   (rd_addr_in),
    .rd_pos_x_out (rd_pos_x_out),
    .rd_pos_y_out (rd_pos_y_out)
  );

  assign busy_out        = (state_q != ST_IDLE);
  assign cfg_ready_out   = !busy_out;
  assign frame_done_out  = (state_q == ST_DONE);
  assign overrun_out     = busy_out && frame_start_in;
  assign timeout_err_out = timeout_err_q;

  // The entry under idx cannot change until WAIT ends, so operands stay stable.
  assign operands_live   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign up.up_begin_out = (state_q == ST_ISSUE);
  assign up.up_pos_x_out = operands_live ? iss_pos_x : '0;
  assign up.up_pos_y_out = operands_live ? iss_pos_y : '0;
  assign up.up_vel_x_out = operands_live ? iss_vel_x : '0;
  assign up.up_vel_y_out = operands_live ? iss_vel_y : '0;

endmodule

// File: tb/tb_point_update_scheduler.sv
// Randomized bench for point_update_scheduler: an engine model answers after a set
// latency, and an array of point records predicts timing, operands and stored data.
`timescale 1ns/1ps
module tb_point_update_scheduler;
  import physics_pkg::*;

  localparam int NP = 8;
  localparam int TO = 64;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       frame_start_in;
  logic       busy_out, frame_done_out, overrun_out, timeout_err_out;
  logic       cfg_we_in;
  logic [2:0] cfg_addr_in;
  logic [7:0] cfg_pos_x_in, cfg_pos_y_in, cfg_vel_x_in, cfg_vel_y_in;
  logic       cfg_ready_out;
  logic [2:0] rd_addr_in;
  logic [7:0] rd_pos_x_out, rd_pos_y_out;

  point_update_scheduler_if #(.POSITION_SIZE(8), .VELOCITY_SIZE(8)) up_if ();

  point_update_scheduler #(
    .POSITION_SIZE(8), .VELOCITY_SIZE(8), .NUM_POINTS(NP), .TIMEOUT(TO)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .busy_out       (busy_out),
    .frame_done_out (frame_done_out),
    .overrun_out    (overrun_out),
    .timeout_err_out(timeout_err_out),
    .cfg_we_in      (cfg_we_in),
    .cfg_addr_in    (cfg_addr_in),
    .cfg_pos_x_in   (cfg_pos_x_in),
    .cfg_pos_y_in   (cfg_pos_y_in),
    .cfg_vel_x_in   (cfg_vel_x_in),
    .cfg_vel_y_in   (cfg_vel_y_in),
    .cfg_ready_out  (cfg_ready_out),
    .rd_addr_in     (rd_addr_in),
    .rd_pos_x_out   (rd_pos_x_out),
    .rd_pos_y_out   (rd_pos_y_out),
    .up             (up_if)
  );

  always #5 clk_in = ~clk_in;

  int     checks   = 0;
  int     failures = 0;
  point_t ref_mem [NP];

  int eng_lat    = 3;
  int eng_silent = -1;
  int eng_count  = 0;
  int eng_cd     = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine: answers L cycles after a begin, computing from the operands it sees then.
  initial begin
    up_if.up_result_in    = 1'b0;
    up_if.up_new_pos_x_in = '0;
    up_if.up_new_pos_y_in = '0;
    up_if.up_new_vel_x_in = '0;
    up_if.up_new_vel_y_in = '0;
    forever begin
      @(negedge clk_in);
      up_if.up_result_in = 1'b0;
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          up_if.up_new_pos_x_in = up_if.up_pos_x_out + up_if.up_vel_x_out;
          up_if.up_new_pos_y_in = up_if.up_pos_y_out + up_if.up_vel_y_out;
          up_if.up_new_vel_x_in = up_if.up_vel_x_out + 8'd1;
          up_if.up_new_vel_y_in = up_if.up_vel_y_out + 8'd1;
          up_if.up_result_in    = 1'b1;
        end
      end
      if (up_if.up_begin_out) begin
        if (eng_count != eng_silent) eng_cd = eng_lat;
        eng_count++;
      end
    end
  end

  task automatic applyStimulus(input int addr, input logic [7:0] px, input logic [7:0] py,
                               input logic [7:0] vx, input logic [7:0] vy);
    @(negedge clk_in);
    cfg_we_in    = 1'b1;
    cfg_addr_in  = 3'(addr);
    cfg_pos_x_in = px;
    cfg_pos_y_in = py;
    cfg_vel_x_in = vx;
    cfg_vel_y_in = vy;
    ref_mem[addr] = '{pos_x: px, pos_y: py, vel_x: vx, vel_y: vy};
    @(negedge clk_in);
    cfg_we_in = 1'b0;
  endtask

  task automatic readPoint(input int addr, output logic [7:0] px, output logic [7:0] py);
    @(negedge clk_in);
    rd_addr_in = 3'(addr);
    @(negedge clk_in);
    #1;
    px = rd_pos_x_out;
    py = rd_pos_y_out;
  endtask

  task automatic checkAll(input string tag);
    logic [7:0] px, py;
    for (int k = 0; k < NP; k++) begin
      readPoint(k, px, py);
      checkOutput($sformatf("%s_pt%0d_x", tag, k), px, ref_mem[k].pos_x);
      checkOutput($sformatf("%s_pt%0d_y", tag, k), py, ref_mem[k].pos_y);
    end
  endtask

  task automatic runFrame(input int lat, input int silent, input int inj_cycle, input bit start_write);
    int     exp_begin [NP];
    int     exp_done;
    int     cyc;
    int     begin_seen;
    int     done_cyc;
    point_t pre [NP];
    eng_lat    = lat;
    eng_silent = silent;
    eng_count  = 0;
    @(negedge clk_in);
    frame_start_in = 1'b1;
    if (start_write) begin
      cfg_we_in    = 1'b1;
      cfg_addr_in  = 3'd0;
      cfg_pos_x_in = 8'd10;
      cfg_pos_y_in = 8'd10;
      cfg_vel_x_in = 8'($urandom_range(0, 255));
      cfg_vel_y_in = 8'($urandom_range(0, 255));
      ref_mem[0] = '{pos_x: 8'd10, pos_y: 8'd10, vel_x: cfg_vel_x_in, vel_y: cfg_vel_y_in};
    end
    pre = ref_mem;
    exp_begin[0] = 1;
    for (int k = 1; k < NP; k++)
      exp_begin[k] = exp_begin[k-1] + 1 + (((k - 1) == silent) ? TO : lat);
    exp_done = exp_begin[NP-1] + 1 + (((NP - 1) == silent) ? TO : lat);
    cyc = 0;
    begin_seen = 0;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < exp_done + 20) begin
      @(negedge clk_in);
      cyc++;
      if (cyc == 1) begin
        frame_start_in = 1'b0;
        cfg_we_in      = 1'b0;
      end
      if (cyc == inj_cycle) begin
        frame_start_in = 1'b1;
        cfg_we_in      = 1'b1;
        cfg_addr_in    = 3'd5;
        cfg_pos_x_in   = 8'($urandom_range(0, 255));
        cfg_pos_y_in   = 8'($urandom_range(0, 255));
      end
      if (cyc == inj_cycle + 1) begin
        frame_start_in = 1'b0;
        cfg_we_in      = 1'b0;
      end
      #1;
      if (cyc == 1) begin
        checkOutput("busy_in_frame", busy_out, 1);
        checkOutput("cfg_ready_in_frame", cfg_ready_out, 0);
        checkOutput("overrun_quiet", overrun_out, 0);
      end
      if (cyc == inj_cycle) checkOutput("overrun_pulse", overrun_out, 1);
      if (cyc == inj_cycle + 1) checkOutput("overrun_cleared", overrun_out, 0);
      if (up_if.up_begin_out) begin
        if (begin_seen < NP) begin
          checkOutput($sformatf("begin%0d_cycle", begin_seen), cyc, exp_begin[begin_seen]);
          checkOutput($sformatf("op%0d_pos_x", begin_seen), up_if.up_pos_x_out, pre[begin_seen].pos_x);
          checkOutput($sformatf("op%0d_pos_y", begin_seen), up_if.up_pos_y_out, pre[begin_seen].pos_y);
          checkOutput($sformatf("op%0d_vel_x", begin_seen), up_if.up_vel_x_out, pre[begin_seen].vel_x);
          checkOutput($sformatf("op%0d_vel_y", begin_seen), up_if.up_vel_y_out, pre[begin_seen].vel_y);
          if (start_write && begin_seen == 0) begin
            checkOutput("same_cycle_write_x", up_if.up_pos_x_out, 10);
            checkOutput("same_cycle_write_y", up_if.up_pos_y_out, 10);
          end
        end
        begin_seen++;
      end
      if (frame_done_out) done_cyc = cyc;
    end
    checkOutput("frame_done_cycle", done_cyc, exp_done);
    checkOutput("begin_count", begin_seen, NP);
    checkOutput("timeout_err", timeout_err_out, (silent >= 0) ? 1 : 0);
    @(negedge clk_in);
    #1;
    checkOutput("idle_after_done", busy_out, 0);
    checkOutput("done_one_cycle", frame_done_out, 0);
    for (int k = 0; k < NP; k++) begin
      if (k != silent) begin
        ref_mem[k].pos_x = pre[k].pos_x + pre[k].vel_x;
        ref_mem[k].pos_y = pre[k].pos_y + pre[k].vel_y;
        ref_mem[k].vel_x = pre[k].vel_x + 8'd1;
        ref_mem[k].vel_y = pre[k].vel_y + 8'd1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] px, py;
    point_t     old_pt;
    int         done_seen;
    int         busy_seen;
    int         sil;
    rst_in         = 1'b0;
    frame_start_in = 1'b0;
    cfg_we_in      = 1'b0;
    cfg_addr_in    = '0;
    cfg_pos_x_in   = '0;
    cfg_pos_y_in   = '0;
    cfg_vel_x_in   = '0;
    cfg_vel_y_in   = '0;
    rd_addr_in     = '0;
    for (int k = 0; k < NP; k++) ref_mem[k] = '0;

    repeat (2) @(negedge clk_in);
    #1;
    checkOutput("rst_busy", busy_out, 0);
    checkOutput("rst_cfg_ready", cfg_ready_out, 1);
    checkOutput("rst_frame_done", frame_done_out, 0);
    checkOutput("rst_overrun", overrun_out, 0);
    checkOutput("rst_timeout_err", timeout_err_out, 0);
    checkOutput("rst_up_begin", up_if.up_begin_out, 0);
    checkOutput("rst_up_pos_x", up_if.up_pos_x_out, 0);
    checkOutput("rst_rd_pos_x", rd_pos_x_out, 0);
    rst_in = 1'b1;

    for (int k = 0; k < NP; k++)
      applyStimulus(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    checkAll("load");

    runFrame(3, -1, -1, 1'b0);
    checkAll("frame_l3");
    runFrame(3, 2, -1, 1'b0);
    checkAll("frame_timeout");
    runFrame(3, -1, 10, 1'b0);
    checkAll("frame_overrun");
    runFrame(3, -1, -1, 1'b1);
    checkAll("frame_samecycle");

    @(negedge clk_in);
    rd_addr_in   = 3'd3;
    old_pt       = ref_mem[3];
    cfg_we_in    = 1'b1;
    cfg_addr_in  = 3'd3;
    cfg_pos_x_in = ~old_pt.pos_x;
    cfg_pos_y_in = ~old_pt.pos_y;
    cfg_vel_x_in = 8'($urandom_range(0, 255));
    cfg_vel_y_in = 8'($urandom_range(0, 255));
    ref_mem[3] = '{pos_x: ~old_pt.pos_x, pos_y: ~old_pt.pos_y,
                   vel_x: cfg_vel_x_in, vel_y: cfg_vel_y_in};
    @(negedge clk_in);
    cfg_we_in = 1'b0;
    #1;
    checkOutput("rd_prewrite_x", rd_pos_x_out, old_pt.pos_x);
    readPoint(3, px, py);
    checkOutput("rd_postwrite_x", px, ref_mem[3].pos_x);

    for (int r = 0; r < 3; r++) begin
      sil = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NP - 1)) : -1;
      runFrame(int'($urandom_range(1, 6)), sil, -1, 1'b0);
      checkAll($sformatf("rand%0d", r));
    end

    eng_lat    = 3;
    eng_silent = -1;
    eng_count  = 0;
    @(negedge clk_in);
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    @(negedge clk_in);
    #1;
    rst_in = 1'b0;
    #0.5;
    checkOutput("async_rst_busy", busy_out, 0);
    checkOutput("async_rst_cfg_ready", cfg_ready_out, 1);
    checkOutput("async_rst_up_pos_x", up_if.up_pos_x_out, 0);
    #0.5;
    rst_in = 1'b1;
    for (int k = 0; k < NP; k++) ref_mem[k] = '0;
    done_seen = 0;
    busy_seen = 0;
    repeat (8) begin
      @(negedge clk_in);
      #1;
      if (frame_done_out) done_seen++;
      if (busy_out) busy_seen++;
    end
    checkOutput("rst_no_frame_done", done_seen, 0);
    checkOutput("rst_stays_idle", busy_seen, 0);
    checkOutput("rst_timeout_err_clear", timeout_err_out, 0);
    checkAll("after_rst");

    for (int k = 0; k < NP; k += 2)
      applyStimulus(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    runFrame(int'($urandom_range(1, 6)), -1, -1, 1'b0);
    checkAll("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/point_update_scheduler.md
POINT_UPDATE_SCHEDULER -- requirements
Module: point_update_scheduler

Interface
REQ-001 SHALL have parameter POSITION_SIZE, default 8, width of x/y positions (unsigned).
REQ-002 SHALL have parameter VELOCITY_SIZE, default 8, width of x/y velocities (two's complement).
REQ-003 SHALL have parameter NUM_POINTS, default 8, number of soft-body points held; AW = max(1, clog2(NUM_POINTS)).
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum number of WAIT cycles per point.
REQ-005 SHALL have port clk_in  input  1  system clock; all logic is rising-edge triggered.
REQ-006 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port frame_start_in  input  1  request to update every point once.
REQ-008 SHALL have ports busy_out  output  1, frame_done_out  output  1 (one-cycle pulse), overrun_out  output  1 (one-cycle pulse), timeout_err_out  output  1 (sticky).
REQ-009 SHALL have host write port cfg_we_in  input  1, cfg_addr_in  input  AW, cfg_pos_x_in/cfg_pos_y_in  input  POSITION_SIZE, cfg_vel_x_in/cfg_vel_y_in  input  VELOCITY_SIZE, cfg_ready_out  output  1.
REQ-010 SHALL have renderer read port rd_addr_in  input  AW, rd_pos_x_out/rd_pos_y_out  output  POSITION_SIZE.
REQ-011 SHALL have update-engine port up_begin_out  output  1, up_pos_x_out/up_pos_y_out  output  POSITION_SIZE, up_vel_x_out/up_vel_y_out  output  VELOCITY_SIZE, up_result_in  input  1, up_new_pos_x_in/up_new_pos_y_in  input  POSITION_SIZE, up_new_vel_x_in/up_new_vel_y_in  input  VELOCITY_SIZE.

Function
REQ-012 SHALL hold NUM_POINTS entries of {pos_x, pos_y, vel_x, vel_y}.
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE; busy_out = (state != IDLE); cfg_ready_out = !busy_out.
REQ-014 SHALL, in IDLE with frame_start_in=1, set idx=0, clear timeout_err_out, and enter ISSUE next cycle.
REQ-015 SHALL, in ISSUE, drive up_begin_out=1 for exactly one cycle with up_* operands = entry[idx], then enter WAIT with wait counter = 0.
REQ-016 SHALL hold up_* operands stable from ISSUE until leaving WAIT.
REQ-017 SHALL, in WAIT with up_result_in=1, write up_new_* into entry[idx] at that edge; if idx=NUM_POINTS-1 go DONE, else idx+1 and go ISSUE.
REQ-018 SHALL, in WAIT with counter reaching TIMEOUT-1 and no up_result_in, leave entry[idx] unchanged, set timeout_err_out, and advance exactly as REQ-017.
REQ-019 SHALL, in DONE, pulse frame_done_out for one cycle and return to IDLE.
REQ-020 SHALL give frame timing: frame_start at cycle 0, first up_begin_out at cycle 1; with engine latency L, up_begin_out for point k at cycle 1+k(L+1); frame_done_out at cycle 1+NUM_POINTS(L+1).
REQ-021 SHALL ignore frame_start_in while busy and pulse overrun_out in that cycle.
REQ-022 SHALL accept cfg_we_in only when cfg_ready_out=1, writing entry[cfg_addr_in] at that edge; writes while busy are dropped.
REQ-023 SHALL, on cfg_we_in and frame_start_in together in IDLE, commit the write and start the frame; ISSUE sees the written value.
REQ-024 SHALL ignore up_result_in outside WAIT, and ignore cfg_addr_in/rd_addr_in >= NUM_POINTS (write dropped, read returns 0).
REQ-025 SHALL register rd_pos_*_out with one-cycle latency from rd_addr_in, readable in any state, returning the pre-write value when the same entry is written in that cycle.

Reset
REQ-026 SHALL, on rst_in=0 (asynchronous, including mid-frame), force state IDLE, idx=0, counter=0, all entries 0, and all outputs 0 except cfg_ready_out=1.
REQ-027 SHALL resume normal operation on the first rising edge after rst_in returns high.

Structure
REQ-028 SHALL take POSITION_SIZE/VELOCITY_SIZE defaults, the point-record struct and the FSM state enum from the shared package physics_pkg.
REQ-029 SHALL place storage in one sub-module point_store (one write port, one ISSUE read port, one registered renderer read port).

Verification
REQ-030 SHALL verify: load 8 points, frame start, engine model with L=3 adding vel to pos -> 8 begins at cycles 1,5,...,29, frame_done at 33, stored pos updated.
REQ-031 SHALL verify: engine never responds for point 2 -> entry 2 unchanged, timeout_err_out=1, other points updated, frame_done asserted.
REQ-032 SHALL verify: frame_start and cfg_we both at cycle 10 during a frame -> overrun_out pulse, write dropped, frame unaffected.
REQ-033 SHALL verify: rst_in low for 1 ns during WAIT -> immediate IDLE, entries 0, no frame_done.
REQ-034 SHALL verify: cfg_we at addr 0 with pos (10,10) plus same-cycle frame_start -> up_pos_x/y_out = 10/10 at first begin.
